// File: rtl/uart_pkg.sv
// uart_pkg: shared frame-controller types: FSM states, error codes, default sync byte
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x DATA_WIDTH payload store; clk, we/waddr/wdata sync write, raddr/rdata async read, no storage reset
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MAX_LEN];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: sync/len/payload/checksum framer; clk, rst_n, rx_data/rx_done in; out_data/out_valid/out_ready/out_last stream; frame_ok, err, err_code, overrun status
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    CLK_FREQ      = 100_000_000,
  parameter int                    BAUD_RATE     = 115200,
  parameter int                    MAX_LEN       = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = DATA_WIDTH'(DEF_SYNC_BYTE),
  parameter int                    TIMEOUT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_ok,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  overrun
);
  localparam int PW  = $clog2(MAX_LEN + 1);
  localparam int AW  = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TMO = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] len, len_n, sum, sum_n, rdata, data_n;
  logic [PW-1:0] wr_ptr, wr_n, rd_ptr, rd_n;
  logic [31:0] gap, gap_n;
  logic [1:0] code_n;
  logic we, ok_n, err_n, ovr_n, vld_n, last_n, counting, tmo;
  uart_frame_buf #(.DATA_WIDTH(DATA_WIDTH), .MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk), .we(we), .waddr(wr_ptr[AW-1:0]), .wdata(rx_data),
    .raddr(rd_n[AW-1:0]), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      sum <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      gap <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      frame_ok <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      sum <= sum_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      gap <= gap_n;
      out_data <= data_n;
      out_valid <= vld_n;
      out_last <= last_n;
      frame_ok <= ok_n;
      err <= err_n;
      err_code <= code_n;
      overrun <= ovr_n;
    end
  always_comb begin
    state_n = state;
    len_n = len;
    sum_n = sum;
    wr_n = wr_ptr;
    rd_n = rd_ptr;
    code_n = err_code;
    ok_n = 1'b0;
    err_n = 1'b0;
    ovr_n = 1'b0;
    we = 1'b0;
    counting = state inside {LEN, PAYLOAD, CHK};
    tmo = counting && !rx_done && gap == 32'(TMO - 1);
    gap_n = counting && !rx_done && !tmo ? gap + 32'd1 : '0;
    case (state)
      IDLE: if (rx_done && rx_data == SYNC_BYTE) state_n = LEN;
      LEN:
        if (rx_done) begin
          len_n = rx_data;
          sum_n = rx_data;
          wr_n = '0;
          if (int'(rx_data) > MAX_LEN) begin
            err_n = 1'b1;
            code_n = ERR_LEN;
          end else state_n = rx_data == '0 ? CHK : PAYLOAD;
        end
      PAYLOAD:
        if (rx_done) begin
          we = 1'b1;
          sum_n = sum + rx_data;
          wr_n = wr_ptr + PW'(1);
          if (DATA_WIDTH'(wr_ptr) == len - DATA_WIDTH'(1)) state_n = CHK;
        end
      CHK:
        if (rx_done) begin
          if (rx_data == sum) begin
            ok_n = 1'b1;
            state_n = len != '0 ? DRAIN : IDLE;
          end else begin
            err_n = 1'b1;
            code_n = ERR_CHK;
          end
        end
      DRAIN: begin
        ovr_n = rx_done;
        if (out_valid && out_ready) begin
          rd_n = out_last ? '0 : rd_ptr + PW'(1);
          state_n = out_last ? IDLE : DRAIN;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      err_n = 1'b1;
      code_n = ERR_TMO;
    end
    if (err_n) begin
      state_n = IDLE;
      sum_n = '0;
      wr_n = '0;
      rd_n = '0;
    end
  end
  // Stream outputs are registered from next-state values so they line up with frame_ok.
  always_comb begin
    vld_n = state_n == DRAIN;
    data_n = vld_n ? rdata : '0;
    last_n = vld_n && DATA_WIDTH'(rd_n) == len_n - DATA_WIDTH'(1);
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for the frame controller
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, rx_done = 1'b0, out_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] out_data;
  logic out_valid, out_last, frame_ok, err, overrun;
  logic [1:0] err_code;
  int tests = 0, fails = 0, err_cnt = 0;

  uart_rx_frame_ctrl #(
    .DATA_WIDTH(8), .CLK_FREQ(1000), .BAUD_RATE(100), .MAX_LEN(16),
    .SYNC_BYTE(8'hA5), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .err(err),
    .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (err) err_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_data, out_valid, out_last, frame_ok, err, err_code, overrun} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {out_data, out_valid, out_last, frame_ok, err, err_code, overrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, frame_ok, err, err_code, overrun} !== 6'h0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h expected 0", {out_valid, frame_ok, err, err_code, overrun});
    end
  endtask

  task automatic test_good_frame;
    int e0;
    e0 = err_cnt;
    out_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    tests++;
    if ({frame_ok, out_valid, out_last, out_data} !== {3'b110, 8'h11}) begin
      fails++;
      $display("FAIL good_first: got %h expected %h", {frame_ok, out_valid, out_last, out_data}, {3'b110, 8'h11});
    end
    @(negedge clk);
    tests++;
    if ({frame_ok, out_valid, out_last, out_data} !== {3'b010, 8'h22}) begin
      fails++;
      $display("FAIL good_second: got %h expected %h", {frame_ok, out_valid, out_last, out_data}, {3'b010, 8'h22});
    end
    @(negedge clk);
    tests++;
    if ({frame_ok, out_valid, out_last, out_data} !== {3'b011, 8'h33}) begin
      fails++;
      $display("FAIL good_third: got %h expected %h", {frame_ok, out_valid, out_last, out_data}, {3'b011, 8'h33});
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL good_drained: out_valid got %b expected 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if (err_cnt !== e0) begin
      fails++;
      $display("FAIL good_no_err: err pulses got %0d expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] got[$];
    logic [8:0] prev;
    logic stalled;
    logic pat[4];
    int last_idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stalled = 1'b0;
    prev = '0;
    last_idx = -1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    for (int i = 0; i < 12; i++) begin
      out_ready = i < 4 ? pat[i] : 1'b1;
      if (stalled) begin
        tests++;
        if ({out_last, out_data} !== prev) begin
          fails++;
          $display("FAIL bp_hold: got %h expected %h", {out_last, out_data}, prev);
        end
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) last_idx = got.size() - 1;
      end
      stalled = out_valid && !out_ready;
      prev = {out_last, out_data};
      @(negedge clk);
    end
    out_ready = 1'b1;
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL bp_count: got %0d bytes expected 3", got.size());
    end else begin
      tests++;
      if ({got[0], got[1], got[2]} !== 24'h112233) begin
        fails++;
        $display("FAIL bp_data: got %h expected 112233", {got[0], got[1], got[2]});
      end
    end
    tests++;
    if (last_idx != 2) begin
      fails++;
      $display("FAIL bp_last: got index %0d expected 2", last_idx);
    end
  endtask

  task automatic test_bad_checksum;
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    tests++;
    if ({err, err_code, out_valid, frame_ok} !== 5'b1_10_0_0) begin
      fails++;
      $display("FAIL chk_err: got %b expected 11000", {err, err_code, out_valid, frame_ok});
    end
    @(negedge clk);
    tests++;
    if ({err, err_code, out_valid} !== 4'b0_10_0) begin
      fails++;
      $display("FAIL chk_hold: got %b expected 0100", {err, err_code, out_valid});
    end
    send(8'hA5); send(8'h00); send(8'h00);
    tests++;
    if ({frame_ok, out_valid, err} !== 3'b100) begin
      fails++;
      $display("FAIL zero_len_ok: got %b expected 100", {frame_ok, out_valid, err});
    end
    @(negedge clk);
    tests++;
    if ({frame_ok, out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL zero_len_no_drain: got %b expected 00", {frame_ok, out_valid});
    end
  endtask

  task automatic test_length_error;
    int e0;
    e0 = err_cnt;
    send(8'hA5); send(8'h11);
    tests++;
    if ({err, err_code} !== 3'b1_01) begin
      fails++;
      $display("FAIL len_err: got %b expected 101", {err, err_code});
    end
    send(8'h22);
    repeat (3) @(negedge clk);
    tests++;
    if ((err_cnt - e0) != 1 || {out_valid, frame_ok, err_code} !== 4'b00_01) begin
      fails++;
      $display("FAIL len_ignore: err pulses %0d flags %b expected 1 and 0001", err_cnt - e0, {out_valid, frame_ok, err_code});
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    send(8'hA5); send(8'h02); send(8'h01);
    while (!err && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 400) begin
      fails++;
      $display("FAIL tmo_cycles: got %0d expected 400", n);
    end
    tests++;
    if (err_code !== 2'd3) begin
      fails++;
      $display("FAIL tmo_code: got %0d expected 3", err_code);
    end
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    tests++;
    if ({frame_ok, out_valid, out_last, out_data} !== {3'b111, 8'h7F}) begin
      fails++;
      $display("FAIL tmo_recover: got %h expected %h", {frame_ok, out_valid, out_last, out_data}, {3'b111, 8'h7F});
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL tmo_recover_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_timeout_edge;
    send(8'hA5);
    repeat (399) @(negedge clk);
    send(8'h00);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_edge_rx_wins: err got %b expected 0", err);
    end
    send(8'h00);
    tests++;
    if ({frame_ok, err, out_valid} !== 3'b100) begin
      fails++;
      $display("FAIL tmo_edge_frame: got %b expected 100", {frame_ok, err, out_valid});
    end
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
    tests++;
    if ({frame_ok, out_valid, out_data} !== {2'b11, 8'hAB}) begin
      fails++;
      $display("FAIL ovr_frame: got %h expected %h", {frame_ok, out_valid, out_data}, {2'b11, 8'hAB});
    end
    send(8'hA5);
    tests++;
    if ({overrun, out_valid, out_data} !== {2'b11, 8'hAB}) begin
      fails++;
      $display("FAIL ovr_pulse: got %h expected %h", {overrun, out_valid, out_data}, {2'b11, 8'hAB});
    end
    @(negedge clk);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_one_cycle: got %b expected 0", overrun);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, out_data} !== {2'b11, 8'hCD}) begin
      fails++;
      $display("FAIL ovr_drain: got %h expected %h", {out_valid, out_last, out_data}, {2'b11, 8'hCD});
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_done: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    send(8'hA5); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_data, out_valid, out_last, frame_ok, err, err_code, overrun} !== 15'h0) begin
      fails++;
      $display("FAIL mid_reset: got %h expected 0", {out_data, out_valid, out_last, frame_ok, err, err_code, overrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    tests++;
    if ({frame_ok, out_valid, out_last, out_data} !== {3'b111, 8'h55}) begin
      fails++;
      $display("FAIL post_reset_frame: got %h expected %h", {frame_ok, out_valid, out_last, out_data}, {3'b111, 8'h55});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_good_frame;
    test_back_pressure;
    test_bad_checksum;
    test_length_error;
    test_timeout;
    test_timeout_edge;
    test_overrun;
    test_reset_mid;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART byte receiver and sequences its output into checked packets. It consumes the receiver's `result`/`done` byte strobe, hunts for a sync byte, collects a length-prefixed payload into a local buffer and verifies a modular checksum. Accepted payloads are drained to a downstream consumer over a valid/ready byte stream. Malformed, timed-out or overrunning traffic is reported on error outputs.

## Interface
- `DATA_WIDTH`, 8: byte width; must match the receiver.
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate; sets bit period `T = CLK_FREQ/BAUD_RATE`.
- `MAX_LEN`, 16: maximum payload bytes; buffer depth; 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_BYTES`, 4: inter-byte gap limit in character times; `TMO = TIMEOUT_BYTES*10*T` cycles.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_data`  in  DATA_WIDTH: received byte; valid only when `rx_done`=1.
- `rx_done`  in  1: one-cycle byte strobe from the receiver.
- `out_data`  out  DATA_WIDTH: payload byte; reset 0.
- `out_valid`  out  1: `out_data` valid; reset 0.
- `out_ready`  in  1: consumer accepts byte.
- `out_last`  out  1: marks final payload byte; reset 0.
- `frame_ok`  out  1: one-cycle pulse, checksum matched; reset 0.
- `err`  out  1: one-cycle pulse on frame error; reset 0.
- `err_code`  out  2: last error, held until next `err`; 1=length, 2=checksum, 3=timeout; reset 0.
- `overrun`  out  1: one-cycle pulse, byte dropped while draining; reset 0.

## Operation
- Frame format: `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CHK`. `CHK = (LEN + sum of payload) mod 256`.
- States:
  - IDLE: on `rx_done`, go to LEN if `rx_data==SYNC_BYTE`; discard anything else.
  - LEN: on `rx_done`, latch `len` and seed `sum=rx_data`, clear `wr_ptr`.
    - `len>MAX_LEN`: error code 1, go to IDLE.
    - `len==0`: go to CHK.
    - otherwise: go to PAYLOAD.
  - PAYLOAD: on `rx_done`, write `buf[wr_ptr]`, `sum+=rx_data`, `wr_ptr++`. Go to CHK when `wr_ptr==len-1` is written.
  - CHK: on `rx_done`:
    - `rx_data==sum`: pulse `frame_ok`; go to DRAIN if `len>0`, else to IDLE.
    - mismatch: error code 2, go to IDLE.
  - DRAIN: `out_valid=1`, `out_data=buf[rd_ptr]`, `out_last=(rd_ptr==len-1)`. On `out_valid&&out_ready`, `rd_ptr++`. After the last transfer, go to IDLE with `rd_ptr=0`.
- Timeout:
  - Gap counter clears on every `rx_done` and counts only in LEN, PAYLOAD and CHK.
  - Reaching `TMO-1` raises error code 3 and returns to IDLE. The partial frame is discarded.
- Overrun: any `rx_done` in DRAIN pulses `overrun`; the byte is dropped. A sync byte arriving there is not honoured.
- Error action: `err` pulses for 1 cycle, `err_code` updates in the same cycle, all pointers and `sum` clear.
- Sum arithmetic: 8-bit, wrap-around, no carry kept.

## Timing
- All outputs are registered.
- `frame_ok`/`err` assert the cycle after the `rx_done` that decides the outcome.
- `out_valid` rises together with `frame_ok`, i.e. 1 cycle after the CHK byte.
- With `out_ready` held high, a frame drains at 1 byte/cycle; `len` cycles from first `out_valid` to `out_last` accepted.
- `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- Timeout and `rx_done` in the same cycle: `rx_done` wins and the counter clears.
- `rst_n` low mid-frame: immediately IDLE, all outputs 0, buffer contents don't-care.
- The frame controller never back-pressures the receiver; it has no ready input to it.

## Structure
- Shared package `uart_pkg` holds:
  - state enum (IDLE, LEN, PAYLOAD, CHK, DRAIN);
  - error-code localparams (`ERR_NONE/LEN/CHK/TMO`);
  - default `SYNC_BYTE`.
- One sub-module, `uart_frame_buf`: `MAX_LEN`×`DATA_WIDTH` register array with one synchronous write port and one asynchronous read port, no reset on storage.
- Pointers are `$clog2(MAX_LEN+1)` bits; the gap counter is 32 bits.

## Test plan
- Good frame: A5,03,11,22,33,69 with `out_ready`=1 → `frame_ok` 1 pulse; outputs 11,22,33 on consecutive cycles; `out_last` on 33; `err` never asserts.
- Back-pressure: same frame, `out_ready` toggling 1-0-0-1 → no byte lost or duplicated; data held during stalls.
- Bad checksum: A5,02,01,02,00 → `err` pulse, `err_code`=2, no `out_valid`. Then a good A5,00,00 → `frame_ok` with no drain.
- Length error: A5,11 with `MAX_LEN`=16 → `err_code`=1. A following 22 is ignored in IDLE.
- Timeout: A5,02,01 then silence for `TMO` cycles → `err_code`=3; the next A5 frame parses correctly.
- Overrun/reset: a byte strobe during DRAIN with `out_ready`=0 → `overrun` pulse and the drained data is unchanged. `rst_n` pulsed mid-PAYLOAD → all outputs 0 and the state returns to IDLE.
